// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types for the MEM-stage access sequencer
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHASE = 2'd1,
    FINAL = 2'd2
  } mem_seq_state_t;

  // Byte-offset width inside one wishbone line; usable in localparam/port ranges.
  function automatic int lc3b_line_off(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/line_lane_sel.sv
// rtl/line_lane_sel.sv - byte-lane steering between one architectural word and a wishbone line
module line_lane_sel
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int WORD_W = 16
) (
  input  logic [lc3b_line_off(LINE_W)-1:0] off,
  input  logic                             is_byte,
  input  logic [WORD_W-1:0]                wdata,
  input  logic [LINE_W-1:0]                dat_s,
  output logic [LINE_W/8-1:0]              sel,
  output logic [LINE_W-1:0]                dat_m,
  output logic [WORD_W-1:0]                rd_word,
  output logic [7:0]                       rd_byte
);

  localparam int OFF_W = lc3b_line_off(LINE_W);
  localparam int SEL_W = LINE_W / 8;
  localparam int WB    = WORD_W / 8;

  logic [OFF_W-1:0] woff;

  // Words are naturally aligned: low offset bits inside a word are ignored.
  assign woff = off & ~OFF_W'(WB - 1);

  always_comb begin
    sel   = '0;
    dat_m = '0;
    if (is_byte) begin
      sel   = SEL_W'(1) << off;
      dat_m = LINE_W'(wdata[7:0]) << {off, 3'b000};
    end else begin
      sel   = SEL_W'({WB{1'b1}}) << woff;
      dat_m = LINE_W'(wdata) << {woff, 3'b000};
    end
  end

  assign rd_word = WORD_W'(dat_s >> {woff, 3'b000});
  assign rd_byte = 8'(dat_s >> {off, 3'b000});

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - MEM-stage sequencer for direct, byte and N-level indirect accesses
module mem_access_seq
  import lc3b_types::*;
#(
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int IND_DEPTH = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  input  logic                                    req_write,
  input  logic                                    req_ind,
  input  logic                                    req_byte,
  input  logic [ADDR_W-1:0]                       req_addr,
  input  logic [WORD_W-1:0]                       req_wdata,
  output logic [WORD_W-1:0]                       rsp_rdata,
  output logic                                    proceed,
  output logic                                    err,
  output logic [ADDR_W-lc3b_line_off(LINE_W)-1:0] wb_adr,
  output logic [LINE_W-1:0]                       wb_dat_m,
  input  logic [LINE_W-1:0]                       wb_dat_s,
  output logic [LINE_W/8-1:0]                     wb_sel,
  output logic                                    wb_we,
  output logic                                    wb_stb,
  output logic                                    wb_cyc,
  input  logic                                    wb_ack
);

  localparam int OFF_W = lc3b_line_off(LINE_W);
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mem_seq_state_t   state_q, state_d;
  logic [2:0]       lvl_q, lvl_d;
  logic             gap_q, gap_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [ADDR_W-1:0] acc_addr;
  logic              is_final, acc_byte, tmo_hit, tmo_now, done, final_done;
  logic [WORD_W-1:0] rd_word;
  logic [7:0]        rd_byte;

  assign acc_addr = (state_q == IDLE) ? req_addr : ptr_q;
  assign is_final = (state_q == FINAL) || ((state_q == IDLE) && !req_ind);
  assign acc_byte = is_final && req_byte;
  assign tmo_hit  = (TIMEOUT > 0) && (tmo_cnt_q == TMO_W'(TIMEOUT));

  // The gap cycle after each completion keeps a held ack from retiring two accesses.
  assign wb_stb     = req_valid && !gap_q && !tmo_hit && !rst;
  assign wb_cyc     = wb_stb;
  assign wb_we      = wb_stb && req_write && is_final;
  assign wb_adr     = acc_addr[ADDR_W-1:OFF_W];
  assign done       = wb_stb && wb_ack;
  assign final_done = done && is_final;
  assign tmo_now    = req_valid && tmo_hit && !rst;
  assign proceed    = rst || !req_valid || final_done || tmo_now;
  assign rsp_rdata  = final_done ? (acc_byte ? WORD_W'(rd_byte) : rd_word) : '0;
  assign err        = err_q;

  line_lane_sel #(
    .LINE_W(LINE_W),
    .WORD_W(WORD_W)
  ) u_lane (
    .off    (acc_addr[OFF_W-1:0]),
    .is_byte(acc_byte),
    .wdata  (req_wdata),
    .dat_s  (wb_dat_s),
    .sel    (wb_sel),
    .dat_m  (wb_dat_m),
    .rd_word(rd_word),
    .rd_byte(rd_byte)
  );

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    gap_d     = done;
    tmo_cnt_d = tmo_cnt_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    if (!req_valid || tmo_hit) begin
      state_d   = IDLE;
      lvl_d     = 3'd0;
      tmo_cnt_d = '0;
    end else if (done) begin
      tmo_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (req_ind) begin
            ptr_d   = ADDR_W'(rd_word);
            lvl_d   = 3'd1;
            state_d = (IND_DEPTH == 1) ? FINAL : CHASE;
          end
        end
        CHASE: begin
          ptr_d = ADDR_W'(rd_word);
          lvl_d = lvl_q + 3'd1;
          if (lvl_q + 3'd1 == 3'(IND_DEPTH)) state_d = FINAL;
        end
        FINAL: begin
          lvl_d   = 3'd0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (wb_stb && (TIMEOUT > 0)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lvl_q     <= 3'd0;
      gap_q     <= 1'b0;
      tmo_cnt_q <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      gap_q     <= gap_d;
      tmo_cnt_q <= tmo_cnt_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
    end
  end

endmodule
